// File: rtl/arb_pkg.sv
// Shared definitions for the arbiter family: state encoding, width helper
// and the legal range of requester counts.
package arb_pkg;

  typedef enum bit {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arbState_e;

  localparam int unsigned ARB_MIN_REQ = 2;
  localparam int unsigned ARB_MAX_REQ = 32;

  // Counter width that never collapses to zero bits, even for tiny limits.
  function automatic int unsigned clog2Min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // True when the requester count is one the arbiters can be built for.
  function automatic bit nReqLegal(input int unsigned n);
    return (n >= ARB_MIN_REQ) && (n <= ARB_MAX_REQ);
  endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// Rotating-priority picker: finds the first set request at or after the
// pointer, wrapping modulo N_REQ, and returns it as one-hot plus index.
module arb_rr_pick
  import arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req_i,
  input  logic [$clog2(N_REQ)-1:0] ptr_i,
  output logic [N_REQ-1:0]         gnt_o,
  output logic [$clog2(N_REQ)-1:0] idx_o,
  output logic                     any_o
);

  localparam int unsigned IW = $clog2(N_REQ);

  // Walk the candidates in priority order starting at the pointer; the first hit wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      int unsigned pos;
      logic [IW-1:0] posW;
      pos  = (32'(ptr_i) + i) % N_REQ;
      posW = IW'(pos);
      if (!any_o && req_i[posW]) begin
        any_o       = 1'b1;
        gnt_o[posW] = 1'b1;
        idx_o       = posW;
      end
    end
  end

endmodule

// File: rtl/arb_rr_hold.sv
// Round-robin arbiter with grant hold: a winner keeps the resource while it
// keeps requesting, and is pushed off after MAX_HOLD cycles if anyone waits.
module arb_rr_hold
  import arb_pkg::*;
#(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned MAX_HOLD   = 8,
  parameter bit          PREEMPT_EN = 1'b1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_cg,
  input  logic [N_REQ-1:0]         i_req,
  output logic [N_REQ-1:0]         o_gnt,
  output logic [$clog2(N_REQ)-1:0] o_gntIdx,
  output logic                     o_busy,
  output logic                     o_preempt
);

  localparam int unsigned IW = $clog2(N_REQ);
  localparam int unsigned CW = clog2Min1(MAX_HOLD);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_REQ - 1);
  localparam logic [CW-1:0] HOLD_MAX = CW'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
  localparam bit PREEMPT_ON = PREEMPT_EN && (MAX_HOLD != 0);

  generate
    if (!nReqLegal(N_REQ)) begin : gBadNReq
      $error("arb_rr_hold: N_REQ must be within 2..32");
    end
  endgenerate

  arbState_e       state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q;
  logic             preempt_q, preempt_d;

  logic [N_REQ-1:0] candReq;
  logic [N_REQ-1:0] pickGnt;
  logic [IW-1:0]    pickIdx;
  logic             pickAny;
  logic [IW-1:0]    pickNext;
  logic             holderReq;

  // While holding, the current holder is never a candidate for the next pick.
  assign candReq   = (state_q == HOLD) ? (i_req & ~gnt_q) : i_req;
  assign holderReq = |(i_req & gnt_q);
  assign pickNext  = (pickIdx == LAST_IDX) ? '0 : pickIdx + IW'(1);

  arb_rr_pick #(
    .N_REQ(N_REQ)
  ) uPick (
    .req_i(candReq),
    .ptr_i(ptr_q),
    .gnt_o(pickGnt),
    .idx_o(pickIdx),
    .any_o(pickAny)
  );

  // Decide the next grant: new grant from idle, hand-over on release, timeout preemption, or keep holding.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    idx_d     = idx_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    preempt_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pickAny) begin
          state_d = HOLD;
          gnt_d   = pickGnt;
          idx_d   = pickIdx;
          ptr_d   = pickNext;
          cnt_d   = '0;
        end
      end
      HOLD: begin
        if (!holderReq) begin
          if (pickAny) begin
            gnt_d = pickGnt;
            idx_d = pickIdx;
            ptr_d = pickNext;
            cnt_d = '0;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            cnt_d   = '0;
          end
        end else if (PREEMPT_ON && (cnt_q == HOLD_MAX) && pickAny) begin
          gnt_d     = pickGnt;
          idx_d     = pickIdx;
          ptr_d     = pickNext;
          cnt_d     = '0;
          preempt_d = 1'b1;
        end else if (cnt_q != HOLD_MAX) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register: reset wins, otherwise update only while the clock gate is open.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      idx_q     <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      preempt_q <= 1'b0;
    end else if (i_cg) begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      idx_q     <= idx_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      busy_q    <= |gnt_d;
      preempt_q <= preempt_d;
    end
  end

  assign o_gnt     = gnt_q;
  assign o_gntIdx  = idx_q;
  assign o_busy    = busy_q;
  assign o_preempt = preempt_q;

endmodule

// File: tb/tb_arb_rr_hold.sv
// Bench for arb_rr_hold: directed scenarios plus random traffic, all checked
// against a tenure-counting reference model of the arbitration rules.
module tb_arb_rr_hold;

  localparam int unsigned N = 4;
  localparam int unsigned MAX_HOLD = 8;

  logic         i_clk;
  logic         i_rst;
  logic         i_cg;
  logic [N-1:0] i_req;
  logic [N-1:0] o_gnt;
  logic [1:0]   o_gntIdx;
  logic         o_busy;
  logic         o_preempt;

  int checkCount;
  int errorCount;

  int mHolder;
  int mTenure;
  int mPtr;
  int mIdx;
  bit mPre;

  arb_rr_hold #(
    .N_REQ(N),
    .MAX_HOLD(MAX_HOLD),
    .PREEMPT_EN(1'b1)
  ) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_cg(i_cg),
    .i_req(i_req),
    .o_gnt(o_gnt),
    .o_gntIdx(o_gntIdx),
    .o_busy(o_busy),
    .o_preempt(o_preempt)
  );

  // Free-running clock.
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // Compare one observed value with its expectation and tally the result.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // First set bit of v searching upward from p with wrap; -1 if none.
  function automatic int pickFrom(input logic [N-1:0] v, input int p);
    for (int i = 0; i < N; i++) begin
      int k;
      k = (p + i) % N;
      if (v[k]) return k;
    end
    return -1;
  endfunction

  task automatic modelGrant(input int w);
    mHolder = w;
    mTenure = 1;
    mIdx    = w;
    mPtr    = (w + 1) % N;
  endtask

  // Advance the reference model by one clock edge using the current inputs.
  task automatic modelStep(input logic [N-1:0] req, input logic cg, input logic rst);
    logic [N-1:0] others;
    int w;
    if (rst) begin
      mHolder = -1;
      mTenure = 0;
      mPtr    = 0;
      mIdx    = 0;
      mPre    = 1'b0;
      return;
    end
    if (!cg) return;
    mPre = 1'b0;
    if (mHolder < 0) begin
      w = pickFrom(req, mPtr);
      if (w >= 0) modelGrant(w);
    end else begin
      others = req;
      others[mHolder] = 1'b0;
      w = pickFrom(others, mPtr);
      if (!req[mHolder]) begin
        if (w >= 0) modelGrant(w);
        else mHolder = -1;
      end else if (mTenure >= MAX_HOLD && w >= 0) begin
        modelGrant(w);
        mPre = 1'b1;
      end else if (mTenure < MAX_HOLD) begin
        mTenure++;
      end
    end
  endtask

  // Drive one cycle of inputs, clock it, then compare every output with the model.
  task automatic applyStimulus(input logic [N-1:0] req, input logic cg, input logic rst);
    logic [N-1:0] expGnt;
    i_req = req;
    i_cg  = cg;
    i_rst = rst;
    modelStep(req, cg, rst);
    @(posedge i_clk);
    #1;
    expGnt = '0;
    if (mHolder >= 0) expGnt[mHolder] = 1'b1;
    checkOutput("gnt", 32'(o_gnt), 32'(expGnt));
    checkOutput("gntIdx", 32'(o_gntIdx), 32'(mIdx));
    checkOutput("busy", 32'(o_busy), 32'(mHolder >= 0));
    checkOutput("preempt", 32'(o_preempt), 32'(mPre));
  endtask

  initial begin
    int pulses;
    logic [N-1:0] r;
    checkCount = 0;
    errorCount = 0;
    mHolder = -1; mTenure = 0; mPtr = 0; mIdx = 0; mPre = 1'b0;
    i_rst = 1'b1;
    i_cg  = 1'b1;
    i_req = '0;

    // Reset state.
    applyStimulus(4'b0000, 1'b1, 1'b1);
    checkOutput("rstGnt", 32'(o_gnt), 32'h0);
    checkOutput("rstBusy", 32'(o_busy), 32'h0);

    // Requesters 0 and 2: 0 wins, holds 8 cycles, then preempted to 2.
    applyStimulus(4'b0101, 1'b1, 1'b0);
    checkOutput("firstGnt", 32'(o_gnt), 32'h1);
    for (int i = 0; i < 7; i++) applyStimulus(4'b0101, 1'b1, 1'b0);
    checkOutput("tenureGnt", 32'(o_gnt), 32'h1);
    applyStimulus(4'b0101, 1'b1, 1'b0);
    checkOutput("preemptGnt", 32'(o_gnt), 32'h4);
    checkOutput("preemptPulse", 32'(o_preempt), 32'h1);
    applyStimulus(4'b0101, 1'b1, 1'b0);
    checkOutput("pulseOneCycle", 32'(o_preempt), 32'h0);

    // Full contention: 4 preemptions in 32 cycles.
    applyStimulus(4'b0000, 1'b1, 1'b1);
    applyStimulus(4'b1111, 1'b1, 1'b0);
    pulses = 0;
    for (int i = 0; i < 32; i++) begin
      applyStimulus(4'b1111, 1'b1, 1'b0);
      if (o_preempt) pulses++;
    end
    checkOutput("pulseCount", 32'(pulses), 32'd4);

    // Holder 2 releases while 0 and 3 wait: no bubble, 3 next; then 3 releases alone.
    applyStimulus(4'b0000, 1'b1, 1'b1);
    applyStimulus(4'b0100, 1'b1, 1'b0);
    applyStimulus(4'b1101, 1'b1, 1'b0);
    applyStimulus(4'b1001, 1'b1, 1'b0);
    checkOutput("handover", 32'(o_gnt), 32'h8);
    checkOutput("handoverPre", 32'(o_preempt), 32'h0);
    applyStimulus(4'b0000, 1'b1, 1'b0);
    checkOutput("idleGnt", 32'(o_gnt), 32'h0);
    checkOutput("idleIdx", 32'(o_gntIdx), 32'h3);

    // Lone requester 1 for 20 cycles, then requester 3 arrives.
    applyStimulus(4'b0000, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) applyStimulus(4'b0010, 1'b1, 1'b0);
    checkOutput("loneHold", 32'(o_gnt), 32'h2);
    applyStimulus(4'b1010, 1'b1, 1'b0);
    checkOutput("lateGnt", 32'(o_gnt), 32'h8);
    checkOutput("latePre", 32'(o_preempt), 32'h1);

    // Clock gate closed for 5 cycles mid-tenure.
    applyStimulus(4'b0000, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(4'b0011, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(4'b1111, 1'b0, 1'b0);
    checkOutput("frozenGnt", 32'(o_gnt), 32'h1);
    for (int i = 0; i < 5; i++) applyStimulus(4'b0011, 1'b1, 1'b0);
    checkOutput("resumeGnt", 32'(o_gnt), 32'h1);
    applyStimulus(4'b0011, 1'b1, 1'b0);
    checkOutput("resumePre", 32'(o_gnt), 32'h2);

    // Reset pulse mid-hold, then lowest index wins.
    applyStimulus(4'b1100, 1'b1, 1'b0);
    applyStimulus(4'b1100, 1'b1, 1'b1);
    checkOutput("midRstGnt", 32'(o_gnt), 32'h0);
    checkOutput("midRstPre", 32'(o_preempt), 32'h0);
    applyStimulus(4'b1110, 1'b1, 1'b0);
    checkOutput("postRstGnt", 32'(o_gnt), 32'h2);

    // Random traffic with sticky requests, occasional gating and resets.
    r = '0;
    for (int i = 0; i < 1500; i++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 7) == 0) r[b] = ~r[b];
      end
      if ($urandom_range(0, 49) == 0) r = N'($urandom);
      applyStimulus(r, ($urandom_range(0, 9) != 0), ($urandom_range(0, 199) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/arb_rr_hold.md
Name: arb_rr_hold

Overview:
Round-robin arbiter that shares one downstream resource between N_REQ requesters.
- A winner keeps its grant for as long as it holds its request, up to a bounded tenure.
- When the tenure expires and another requester is waiting, the grant is preempted and passed on.
- It sits in front of shared buses and memories so that no single requester can starve the others.

Parameters:
N_REQ, 4, int unsigned; number of requesters, legal range 2..32; elaboration error otherwise.
MAX_HOLD, 8, int unsigned; maximum consecutive granted cycles before preemption; 0 = unlimited tenure.
PREEMPT_EN, 1, bit; 0 disables preemption entirely (equivalent to MAX_HOLD=0).

Ports:
i_clk  input  1  clock; all state updates on rising edge.
i_rst  input  1  synchronous, active-high reset.
i_cg  input  1  clock-gate enable; 0 freezes all state and outputs.
i_req  input  N_REQ  request vector, one bit per requester, level-sensitive.
o_gnt  output  N_REQ  registered grant, one-hot or zero.
o_gntIdx  output  $clog2(N_REQ)  binary index of current/last holder.
o_busy  output  1  registered; 1 when o_gnt is nonzero.
o_preempt  output  1  one-cycle pulse in the cycle the grant first moves because of timeout.

Behaviour:
- Reset (i_rst=1 at edge, overrides i_cg):
  - o_gnt=0, o_gntIdx=0, o_busy=0, o_preempt=0.
  - Rotation pointer ptr=0, so requester 0 has highest priority first.
  - holdCnt=0, state=IDLE.
- i_cg=0 and i_rst=0: every register holds its value. Requests seen only while i_cg=0 are not remembered.
- Pick function:
  - Select the first asserted bit of a candidate vector, searching from ptr upward with wrap modulo N_REQ.
  - ptr is always (last winner index + 1) mod N_REQ; N_REQ that is not a power of two wraps correctly.
- States:
  - IDLE: o_gnt=0.
    - Any i_req bit set -> next cycle o_gnt = pick(i_req), go to HOLD, holdCnt=0.
    - No request -> stay in IDLE.
    - Latency from request to grant is exactly 1 cycle.
  - HOLD, holder h:
    - Release: i_req[h]=0 -> next cycle grant pick(i_req with bit h masked), with ptr=h+1.
      - If no other request is pending -> IDLE, o_gnt=0.
      - No bubble cycle when handing over to another requester.
    - Preempt: i_req[h]=1, preemption enabled, holdCnt==MAX_HOLD-1, and another bit set.
      - Next cycle grant moves to pick(others), ptr=h+1, holdCnt=0, o_preempt=1 for that one cycle.
    - Continue: otherwise h keeps the grant.
      - holdCnt increments, saturating at MAX_HOLD-1.
      - If alone at saturation, h keeps the grant indefinitely, and is preempted as soon as another request appears.
- holdCnt width is max(1,$clog2(MAX_HOLD)). MAX_HOLD=1 means alternation every cycle under contention.
- o_gntIdx updates together with o_gnt and holds the last holder in IDLE.
- Simultaneous release and timeout: treated as release, so o_preempt=0.
- Requests dropping in the same cycle as a grant are ignored for that grant. The grant lasts at least 1 cycle, then releases next cycle.
- o_gnt is never multi-hot, and never asserts a bit whose i_req was 0 in the deciding cycle.
- Reset mid-HOLD: the grant is removed on the next edge with no o_preempt pulse.

Decomposition:
- Package arb_pkg holds:
  - Function clog2Min1(int unsigned).
  - Typedef for the state enum (IDLE, HOLD), 1b, 2-state.
  - Localparam legality checks, shared with other arbiters.
- Sub-module arb_rr_pick: combinational rotate-priority picker.
  - Inputs: N_REQ vector and ptr.
  - Outputs: one-hot vector, index, and any.
  - Reused by future weighted arbiters.

Test Plan:
- Reset, then i_req=4'b0101 held -> cycle 1 o_gnt=0001, o_gntIdx=0; requester 0 keeps the grant 8 cycles; then o_gnt=0100 with o_preempt=1 for 1 cycle.
- i_req=4'b1111 continuously, MAX_HOLD=8 -> grant sequence 0,1,2,3,0 each lasting exactly 8 cycles; 4 o_preempt pulses per 32 cycles.
- Holder 2 drops its request while 0 and 3 wait -> next cycle o_gnt=1000 with no bubble, o_preempt=0; then holder 3 drops with nothing pending -> o_gnt=0, o_busy=0.
- Only requester 1 requests for 20 cycles (MAX_HOLD=8) -> no preemption; requester 3 asserts at cycle 20 -> o_gnt=1000 at cycle 21 with o_preempt=1.
- i_cg=0 for 5 cycles mid-HOLD with contention -> o_gnt and holdCnt frozen; the tenure completes after i_cg returns to 1.
- i_rst=1 pulsed during HOLD -> next edge o_gnt=0, o_gntIdx=0, o_preempt=0; after release the first grant goes to the lowest-index requester.
